dpwm_sequencer: RTL and testbench

//   Sequences the 10-bit progressive DPWM counter (0..TOP in steps of STEP).

---
 rtl/dpwm_sequencer.sv | 157 +++++++++++++++
 tb/tb_dpwm_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/dpwm_sequencer.sv
// dpwm_sequencer: controls an external progressive DPWM counter (0..TOP in STEP
// increments). Generates the counter clock-enable at a selectable rate, holds the
// counter in reset while stopped, and keeps a duty setpoint that is only adopted
// at period boundaries. pwm_out is a registered compare of cuenta against the
// active duty.
//
// Handshake note: there is no valid/ready traffic here. cnt_ce is a 1-CLK strobe
// and the counter must advance on exactly the CLK edge where cnt_ce=1;
// duty_up/duty_down are single-CLK pulses, each sampled once per edge.
module dpwm_sequencer #(
  parameter int W    = 10,
  parameter int STEP = 50,
  parameter int TOP  = 1000,
  parameter int DIV0 = 1,
  parameter int DIV1 = 10,
  parameter int DIV2 = 100,
  parameter int DIV3 = 1000
) (
  input  logic         CLK,
  input  logic         reset,
  input  logic         enable,
  input  logic [1:0]   freq_sel,
  input  logic         duty_up,
  input  logic         duty_down,
  input  logic [W-1:0] cuenta,
  output logic         cnt_ce,
  output logic         cnt_rst,
  output logic [W-1:0] duty_pending,
  output logic [W-1:0] duty_active,
  output logic         period_start,
  output logic         pwm_out,
  output logic         running,
  output logic [1:0]   state_dbg
);

  // Reset duty: half of TOP, rounded down to a STEP multiple.
  localparam logic [W-1:0] DUTY_RST = W'((TOP / 2 / STEP) * STEP);
  localparam logic [W-1:0] TOP_W    = W'(TOP);
  localparam logic [W:0]   TOP_W1   = (W+1)'(TOP);
  localparam logic [W-1:0] STEP_W   = W'(STEP);
  localparam logic [W:0]   STEP_W1  = (W+1)'(STEP);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t       state, state_n;
  logic [15:0]  div_cnt, div_cnt_n;
  logic [15:0]  div_active, div_active_n;
  logic [15:0]  div_sel;
  logic [W-1:0] duty_active_n;
  logic [W-1:0] duty_pending_n;
  logic [W:0]   sum_up;
  logic         pstart_n;
  logic         ce_n;
  logic         pwm_n;

  assign running   = (state == RUN);
  assign state_dbg = state;

  // Divider length selected by freq_sel; only sampled at START or a boundary.
  always_comb begin
    div_sel = 16'(DIV0);
    case (freq_sel)
      2'd0:    div_sel = 16'(DIV0);
      2'd1:    div_sel = 16'(DIV1);
      2'd2:    div_sel = 16'(DIV2);
      default: div_sel = 16'(DIV3);
    endcase
  end

  // FSM next state, divider, period boundary handling and next-cycle strobes.
  always_comb begin
    state_n       = state;
    div_cnt_n     = div_cnt;
    div_active_n  = div_active;
    duty_active_n = duty_active;
    pstart_n      = 1'b0;
    case (state)
      IDLE: begin
        div_cnt_n = '0;
        if (enable) state_n = START;
      end
      START: begin
        div_cnt_n = '0;
        if (!enable) begin
          state_n = IDLE;
        end else begin
          state_n       = RUN;
          duty_active_n = duty_pending;
          div_active_n  = div_sel;
          pstart_n      = 1'b1;
        end
      end
      RUN: begin
        if (!enable) begin
          state_n   = IDLE;
          div_cnt_n = '0;
        end else begin
          if (div_cnt == div_active - 16'd1) div_cnt_n = '0;
          else                               div_cnt_n = div_cnt + 16'd1;
          // Boundary: the counter wraps TOP->0 on this edge.
          if (cnt_ce && (cuenta == TOP_W)) begin
            duty_active_n = duty_pending;
            div_active_n  = div_sel;
            pstart_n      = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    // cnt_ce is registered, so it is decoded from the next-cycle divider state.
    ce_n  = (state_n == RUN) && (div_cnt_n == div_active_n - 16'd1);
    pwm_n = (state == RUN) && enable && (cuenta < duty_active);
  end

  // Saturating setpoint update; computed one bit wider so it never wraps.
  always_comb begin
    sum_up         = {1'b0, duty_pending} + STEP_W1;
    duty_pending_n = duty_pending;
    if (duty_up && !duty_down) begin
      if (sum_up > TOP_W1) duty_pending_n = TOP_W;
      else                 duty_pending_n = sum_up[W-1:0];
    end else if (duty_down && !duty_up) begin
      if (duty_pending < STEP_W) duty_pending_n = '0;
      else                       duty_pending_n = duty_pending - STEP_W;
    end
  end

  // State and output registers; reset overrides everything including the setpoint.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state        <= IDLE;
      div_cnt      <= '0;
      div_active   <= 16'(DIV0);
      duty_active  <= DUTY_RST;
      duty_pending <= DUTY_RST;
      cnt_ce       <= 1'b0;
      cnt_rst      <= 1'b1;
      period_start <= 1'b0;
      pwm_out      <= 1'b0;
    end else begin
      state        <= state_n;
      div_cnt      <= div_cnt_n;
      div_active   <= div_active_n;
      duty_active  <= duty_active_n;
      duty_pending <= duty_pending_n;
      cnt_ce       <= ce_n;
      cnt_rst      <= (state_n != RUN);
      period_start <= pstart_n;
      pwm_out      <= pwm_n;
    end
  end

endmodule

// File: tb/tb_dpwm_sequencer.sv
// Bench for dpwm_sequencer: a behavioural progressive counter closes the loop,
// directed scenarios check the control outputs, and a scoreboard predicts pwm_out.
module tb_dpwm_sequencer;
  localparam int W = 10;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic         reset, enable, duty_up, duty_down;
  logic [1:0]   freq_sel;
  logic [W-1:0] cuenta = '0;
  logic         cnt_ce, cnt_rst, period_start, pwm_out, running;
  logic [W-1:0] duty_pending, duty_active;
  logic [1:0]   state_dbg;

  int n_cmp = 0;
  int n_err = 0;

  dpwm_sequencer dut (
    .CLK(CLK), .reset(reset), .enable(enable), .freq_sel(freq_sel),
    .duty_up(duty_up), .duty_down(duty_down), .cuenta(cuenta),
    .cnt_ce(cnt_ce), .cnt_rst(cnt_rst), .duty_pending(duty_pending),
    .duty_active(duty_active), .period_start(period_start),
    .pwm_out(pwm_out), .running(running), .state_dbg(state_dbg)
  );

  // External 10-bit progressive counter: 0..1000 step 50.
  always @(posedge CLK) begin
    if (cnt_rst)     cuenta <= '0;
    else if (cnt_ce) cuenta <= (cuenta == 10'd1000) ? 10'd0 : cuenta + 10'd50;
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- scoreboard for pwm_out ----------------
  logic         sb_en   = 1'b0;
  logic [W-1:0] sb_duty = 10'd500;
  logic [0:0]   exp_q[$];

  // Expected pwm for the current cuenta is queued, compared after the next edge.
  always @(posedge CLK) begin
    #1;
    if (sb_en) begin
      if (exp_q.size() > 0) begin
        logic [0:0] e;
        e = exp_q.pop_front();
        check("pwm_sb", int'(pwm_out), int'(e));
      end
      exp_q.push_back(cuenta < sb_duty);
    end else begin
      exp_q.delete();
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse(input logic up, input logic dn);
    duty_up = up; duty_down = dn;
    @(negedge CLK);
    duty_up = 1'b0; duty_down = 1'b0;
  endtask

  task automatic wait_cuenta(input logic [W-1:0] v, input int budget);
    int n = 0;
    while (cuenta != v && n < budget) begin @(negedge CLK); n++; end
    check("wait_cuenta", int'(cuenta), int'(v));
  endtask

  task automatic wait_pstart(input int budget);
    int n = 0;
    while (!period_start && n < budget) begin @(negedge CLK); n++; end
    check("wait_pstart", int'(period_start), 1);
  endtask

  task automatic measure_gap(input int budget, output int gap);
    int n = 0;
    while (!cnt_ce && n < budget) begin @(negedge CLK); n++; end
    gap = 0;
    do begin @(negedge CLK); gap++; end while (!cnt_ce && gap < budget);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_state"}, int'(state_dbg), 0);
    check({tag, "_cnt_rst"}, int'(cnt_rst), 1);
    check({tag, "_cnt_ce"}, int'(cnt_ce), 0);
    check({tag, "_pwm"}, int'(pwm_out), 0);
    check({tag, "_pstart"}, int'(period_start), 0);
    check({tag, "_running"}, int'(running), 0);
    check({tag, "_pending"}, int'(duty_pending), 500);
    check({tag, "_active"}, int'(duty_active), 500);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int gap;
    int exp_p;
    reset = 1'b1; enable = 1'b0; freq_sel = 2'd0; duty_up = 1'b0; duty_down = 1'b0;
    repeat (3) @(negedge CLK);
    check_reset_vals("rst");

    // 1: start at full rate
    enable = 1'b1; reset = 1'b0;
    @(negedge CLK);
    check("t1_start_state", int'(state_dbg), 1);
    check("t1_start_cnt_rst", int'(cnt_rst), 1);
    check("t1_start_ce", int'(cnt_ce), 0);
    check("t1_start_running", int'(running), 0);
    sb_duty = 10'd500; sb_en = 1'b1;
    @(negedge CLK);
    check("t1_run_state", int'(state_dbg), 2);
    check("t1_run_running", int'(running), 1);
    check("t1_run_cnt_rst", int'(cnt_rst), 0);
    check("t1_run_ce", int'(cnt_ce), 1);
    check("t1_run_pstart", int'(period_start), 1);
    check("t1_run_cuenta", int'(cuenta), 0);
    check("t1_run_active", int'(duty_active), 500);
    for (int i = 0; i < 42; i++) begin
      @(negedge CLK);
      check("t1_ce_every", int'(cnt_ce), 1);
      check("t1_pstart_at0", int'(period_start), int'(cuenta == 10'd0));
    end

    // 2: rate changes only at the boundary
    freq_sel = 2'd1;
    measure_gap(300, gap);
    check("t2_gap_still1", gap, 1);
    wait_cuenta(10'd1000, 30);
    wait_pstart(30);
    measure_gap(300, gap);
    check("t2_gap10", gap, 10);
    freq_sel = 2'd2;
    measure_gap(300, gap);
    check("t2_gap_still10", gap, 10);
    wait_cuenta(10'd1000, 300);
    wait_pstart(20);
    check("t2_pstart_cuenta", int'(cuenta), 0);
    measure_gap(300, gap);
    check("t2_gap100", gap, 100);
    enable = 1'b0; sb_en = 1'b0; freq_sel = 2'd0;
    @(negedge CLK);
    check("t2_stop_state", int'(state_dbg), 0);
    check("t2_stop_cnt_rst", int'(cnt_rst), 1);

    // 3: setpoint saturation (while idle)
    exp_p = 500;
    for (int i = 0; i < 11; i++) begin
      pulse(1'b1, 1'b0);
      exp_p = (exp_p + 50 > 1000) ? 1000 : exp_p + 50;
      check("t3_up", int'(duty_pending), exp_p);
    end
    check("t3_up_sat", int'(duty_pending), 1000);
    for (int i = 0; i < 25; i++) pulse(1'b0, 1'b1);
    check("t3_down_sat", int'(duty_pending), 0);
    pulse(1'b1, 1'b1);
    check("t3_both_at0", int'(duty_pending), 0);
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b1);
    check("t3_both_at50", int'(duty_pending), 50);
    check("t3_active_held", int'(duty_active), 500);
    for (int i = 0; i < 9; i++) pulse(1'b1, 1'b0);
    check("t3_back500", int'(duty_pending), 500);

    // 4: setpoint adopted only at the boundary
    enable = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    check("t4_active", int'(duty_active), 500);
    sb_duty = 10'd500; sb_en = 1'b1;
    wait_cuenta(10'd300, 30);
    pulse(1'b1, 1'b0);
    check("t4_pending550", int'(duty_pending), 550);
    check("t4_active_mid", int'(duty_active), 500);
    wait_cuenta(10'd1000, 30);
    check("t4_active_top", int'(duty_active), 500);
    pulse(1'b1, 1'b0);
    check("t4_pstart", int'(period_start), 1);
    check("t4_cuenta0", int'(cuenta), 0);
    check("t4_active550", int'(duty_active), 550);
    check("t4_pending600", int'(duty_pending), 600);
    sb_duty = 10'd550;

    // 5: enable dropped mid-period, then restart
    wait_cuenta(10'd300, 30);
    enable = 1'b0; sb_en = 1'b0;
    @(negedge CLK);
    check("t5_pwm", int'(pwm_out), 0);
    check("t5_cnt_rst", int'(cnt_rst), 1);
    check("t5_ce", int'(cnt_ce), 0);
    check("t5_running", int'(running), 0);
    check("t5_state", int'(state_dbg), 0);
    check("t5_pending", int'(duty_pending), 600);
    enable = 1'b1;
    @(negedge CLK);
    check("t5_restart_state", int'(state_dbg), 1);
    check("t5_restart_cnt_rst", int'(cnt_rst), 1);
    check("t5_restart_cuenta", int'(cuenta), 0);
    @(negedge CLK);
    check("t5_run_pstart", int'(period_start), 1);
    check("t5_run_cuenta", int'(cuenta), 0);
    check("t5_run_active", int'(duty_active), 600);
    check("t5_run_cnt_rst", int'(cnt_rst), 0);

    // 6: reset while running with a raised setpoint
    repeat (4) pulse(1'b1, 1'b0);
    check("t6_pending800", int'(duty_pending), 800);
    repeat (3) @(negedge CLK);
    reset = 1'b1;
    @(negedge CLK);
    check_reset_vals("t6");
    reset = 1'b0; enable = 1'b0;
    @(negedge CLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
